// File: rtl/game_input_frontend.sv
// Game input front end: button sync/debounce, press and auto-repeat events, event FIFO.
// Define PS2_KEYS_EN to merge PS/2 extended arrow keys into channels 0..3.
module game_input_frontend #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 40000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int FIFO_DEPTH      = 8,
    localparam int CW = (N_BTN > 1) ? $clog2(N_BTN) : 1,
    localparam int AW = $clog2(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn,
    input  logic             kb_valid,
    input  logic [7:0]       kb_code,
    output logic [N_BTN-1:0] held,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CW-1:0]    evt_chan,
    output logic             evt_repeat,
    output logic [AW:0]      evt_count,
    output logic             dropped
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = (RMAX < 1) ? 1 : $clog2(RMAX + 1);

    logic [N_BTN-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N_BTN-1:0] stable_q, stable_d, lvl_prev_q, lvl_prev_d;
    logic [N_BTN-1:0] rep_arm_q, rep_arm_d, pend_q, pend_d, rtype_q, rtype_d;
    logic [DW-1:0]    deb_cnt_q [N_BTN];
    logic [DW-1:0]    deb_cnt_d [N_BTN];
    logic [HW-1:0]    hold_cnt_q [N_BTN];
    logic [HW-1:0]    hold_cnt_d [N_BTN];
    logic [CW:0]      mem_q [FIFO_DEPTH];
    logic [CW:0]      mem_d [FIFO_DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             drop_q, drop_d;

    logic [N_BTN-1:0] kb_lvl, lvl, press, rep, req, grant;
    logic [CW-1:0]    win;
    logic [AW:0]      count;
    logic [CW:0]      head;
    logic             pop, push, full;

`ifdef PS2_KEYS_EN
    typedef enum logic [1:0] {
        KB_IDLE,
        KB_EXT,
        KB_BRK,
        KB_EXT_BRK
    } kb_state_e;

    kb_state_e  kb_state_q, kb_state_d;
    logic [3:0] kb_lvl_q, kb_lvl_d;
    logic       kb_hit;
    logic [1:0] kb_idx;

    always_comb begin
        kb_state_d = kb_state_q;
        kb_lvl_d   = kb_lvl_q;
        kb_hit     = 1'b1;
        kb_idx     = 2'd0;
        case (kb_code)
            8'h74:   kb_idx = 2'd0;
            8'h75:   kb_idx = 2'd1;
            8'h6B:   kb_idx = 2'd2;
            8'h72:   kb_idx = 2'd3;
            default: kb_hit = 1'b0;
        endcase
        if (kb_valid) begin
            unique case (kb_state_q)
                KB_IDLE: begin
                    if (kb_code == 8'hE0) kb_state_d = KB_EXT;
                    else if (kb_code == 8'hF0) kb_state_d = KB_BRK;
                end
                KB_EXT: begin
                    if (kb_code == 8'hF0) begin
                        kb_state_d = KB_EXT_BRK;
                    end else begin
                        if (kb_hit) kb_lvl_d[kb_idx] = 1'b1;
                        kb_state_d = KB_IDLE;
                    end
                end
                KB_BRK: kb_state_d = KB_IDLE;
                KB_EXT_BRK: begin
                    if (kb_hit) kb_lvl_d[kb_idx] = 1'b0;
                    kb_state_d = KB_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kb_state_q <= KB_IDLE;
            kb_lvl_q   <= '0;
        end else begin
            kb_state_q <= kb_state_d;
            kb_lvl_q   <= kb_lvl_d;
        end
    end

    always_comb begin
        kb_lvl      = '0;
        kb_lvl[3:0] = kb_lvl_q;
    end
`else
    logic unused_kb;
    assign unused_kb = ^{kb_valid, kb_code};
    assign kb_lvl    = '0;
`endif

    assign lvl   = stable_q | kb_lvl;
    assign count = wr_ptr_q - rd_ptr_q;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        sync1_d    = btn;
        sync2_d    = sync1_q;
        stable_d   = stable_q;
        deb_cnt_d  = deb_cnt_q;
        lvl_prev_d = lvl;
        hold_cnt_d = hold_cnt_q;
        rep_arm_d  = rep_arm_q;
        press      = lvl & ~lvl_prev_q;
        rep        = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                deb_cnt_d[i] = '0;
                stable_d[i]  = ~stable_q[i];
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
            // Counter restarts at 1 so the period counts the firing cycle too.
            hold_cnt_d[i] = '0;
            rep_arm_d[i]  = 1'b0;
            if (lvl[i] && REPEAT_PERIOD != 0) begin
                rep_arm_d[i] = rep_arm_q[i];
                if (hold_cnt_q[i] == (rep_arm_q[i] ? HW'(REPEAT_PERIOD)
                                                   : HW'(REPEAT_DELAY))) begin
                    rep[i]        = 1'b1;
                    hold_cnt_d[i] = HW'(1);
                    rep_arm_d[i]  = 1'b1;
                end else begin
                    hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
                end
            end
        end
        req = press | rep;

        win = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pend_q[i]) win = CW'(i);
        end
        full  = (count == (AW + 1)'(FIFO_DEPTH));
        pop   = (count != '0) && evt_ready;
        push  = (|pend_q) && (!full || pop);
        grant = '0;
        for (int i = 0; i < N_BTN; i++) begin
            grant[i] = push && (win == CW'(i));
        end

        pend_d = (pend_q & ~grant) | (req & ~pend_q);
        for (int i = 0; i < N_BTN; i++) begin
            rtype_d[i] = (req[i] && !pend_q[i]) ? rep[i] : rtype_q[i];
        end
        drop_d = drop_q | (|(req & pend_q));

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q[AW-1:0]] = {win, rtype_q[win]};
        wr_ptr_d = wr_ptr_q + (AW + 1)'(push);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            lvl_prev_q <= '0;
            rep_arm_q  <= '0;
            pend_q     <= '0;
            rtype_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            drop_q     <= 1'b0;
            for (int i = 0; i < N_BTN; i++) begin
                deb_cnt_q[i]  <= '0;
                hold_cnt_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            stable_q   <= stable_d;
            lvl_prev_q <= lvl_prev_d;
            rep_arm_q  <= rep_arm_d;
            pend_q     <= pend_d;
            rtype_q    <= rtype_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            drop_q     <= drop_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            mem_q      <= mem_d;
        end
    end

    assign held       = lvl;
    assign evt_valid  = (count != '0);
    assign evt_chan   = head[CW:1];
    assign evt_repeat = head[0];
    assign evt_count  = count;
    assign dropped    = drop_q;

endmodule

// File: tb/tb_game_input_frontend.sv
// Bench for game_input_frontend: event-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_game_input_frontend;

    localparam int NB  = 4;
    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int FD  = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] btn = '0;
    logic          kb_valid = 1'b0;
    logic [7:0]    kb_code = '0;
    logic          evt_ready = 1'b0;
    logic [NB-1:0] held;
    logic          evt_valid;
    logic [1:0]    evt_chan;
    logic          evt_repeat;
    logic [2:0]    evt_count;
    logic          dropped;

    always #5 clk = ~clk;

    game_input_frontend #(
        .N_BTN(NB),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY(RD),
        .REPEAT_PERIOD(RP),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn(btn),
        .kb_valid(kb_valid),
        .kb_code(kb_code),
        .held(held),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_chan(evt_chan),
        .evt_repeat(evt_repeat),
        .evt_count(evt_count),
        .dropped(dropped)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: pin history, run-length debounce, hold age, queue of events.
    bit [NB-1:0] m_s0, m_s1, m_stable, m_pend, m_rtype, m_kb;
    int          m_run [NB];
    int          m_age [NB];
    bit          m_drop;
    int          m_q [$];
    logic [7:0]  m_seq [$];

    function automatic int kmap(input logic [7:0] b);
        case (b)
            8'h74:   return 0;
            8'h75:   return 1;
            8'h6B:   return 2;
            8'h72:   return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_step();
        bit [NB-1:0] h, oldp, rq, rp;
        bit          pop, push;
        int          w, k;
        if (reset) begin
            m_s0 = '0; m_s1 = '0; m_stable = '0; m_pend = '0;
            m_rtype = '0; m_kb = '0; m_drop = 1'b0;
            for (int i = 0; i < NB; i++) begin
                m_run[i] = 0;
                m_age[i] = 0;
            end
            m_q.delete();
            m_seq.delete();
        end else begin
            h    = m_stable | m_kb;
            oldp = m_pend;
            pop  = (m_q.size() > 0) && evt_ready;
            w    = -1;
            for (int i = 0; i < NB; i++) if (oldp[i] && w < 0) w = i;
            push = (w >= 0) && ((m_q.size() < FD) || pop);
            for (int i = 0; i < NB; i++) begin
                rp[i] = h[i] && (m_age[i] >= RD) && (((m_age[i] - RD) % RP) == 0);
                rq[i] = (h[i] && m_age[i] == 0) || rp[i];
            end
            if (pop) void'(m_q.pop_front());
            if (push) begin
                m_q.push_back(w * 2 + int'(m_rtype[w]));
                m_pend[w] = 1'b0;
            end
            for (int i = 0; i < NB; i++) begin
                if (rq[i]) begin
                    if (oldp[i]) m_drop = 1'b1;
                    else begin
                        m_pend[i]  = 1'b1;
                        m_rtype[i] = rp[i];
                    end
                end
                m_age[i] = h[i] ? m_age[i] + 1 : 0;
                if (m_s1[i] != m_stable[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_stable[i] = ~m_stable[i];
                        m_run[i]    = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_s1 = m_s0;
            m_s0 = btn;
`ifdef PS2_KEYS_EN
            if (kb_valid) begin
                m_seq.push_back(kb_code);
                if (m_seq[0] == 8'hE0) begin
                    if (m_seq.size() == 2 && m_seq[1] != 8'hF0) begin
                        k = kmap(m_seq[1]);
                        if (k >= 0) m_kb[k] = 1'b1;
                        m_seq.delete();
                    end else if (m_seq.size() == 3) begin
                        k = kmap(m_seq[2]);
                        if (k >= 0) m_kb[k] = 1'b0;
                        m_seq.delete();
                    end
                end else if (m_seq[0] == 8'hF0) begin
                    if (m_seq.size() == 2) m_seq.delete();
                end else begin
                    m_seq.delete();
                end
            end
`else
            k = 0;
`endif
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check("m_held", held, m_stable | m_kb);
            check("m_valid", evt_valid, m_q.size() > 0);
            check("m_count", evt_count, m_q.size());
            check("m_dropped", dropped, m_drop);
            if (m_q.size() > 0) begin
                check("m_chan", evt_chan, m_q[0] / 2);
                check("m_repeat", evt_repeat, m_q[0] % 2);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        kb_code  = b;
        kb_valid = 1'b1;
        tick(1);
        kb_valid = 1'b0;
        tick(1);
    endtask

    logic [NB-1:0] mx;
    int            nev;
    int            t_ev [8];
    logic          r_ev [8];

    initial begin
        reset = 1'b1;
        tick(3);
        check("rst_held", held, 0);
        check("rst_valid", evt_valid, 0);
        check("rst_count", evt_count, 0);
        check("rst_dropped", dropped, 0);
        reset = 1'b0;
        tick(2);

        // Short glitch is rejected, then a proper press.
        btn[1] = 1'b1;
        tick(3);
        btn[1] = 1'b0;
        mx = '0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            mx = mx | held;
        end
        check("glitch_held", mx, 0);
        check("glitch_count", evt_count, 0);
        btn[1] = 1'b1;
        tick(5);
        check("held1_c5", held[1], 0);
        tick(1);
        check("held1_c6", held[1], 1);
        tick(4);
        btn[1] = 1'b0;
        tick(12);
        check("press1_count", evt_count, 1);
        check("press1_chan", evt_chan, 1);
        check("press1_rep", evt_repeat, 0);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("press1_pop", evt_count, 0);

        // Auto-repeat timing.
        evt_ready = 1'b1;
        btn[0] = 1'b1;
        nev = 0;
        for (int c = 1; c <= 75; c++) begin
            tick(1);
            if (c == 50) btn[0] = 1'b0;
            if (evt_valid) begin
                if (nev < 8) begin
                    t_ev[nev] = c;
                    r_ev[nev] = evt_repeat;
                end
                nev++;
            end
        end
        evt_ready = 1'b0;
        check("rep_nev", nev, 5);
        check("rep_t0", t_ev[0], 8);
        check("rep_r0", r_ev[0], 0);
        check("rep_d1", t_ev[1] - t_ev[0], 20);
        check("rep_d2", t_ev[2] - t_ev[0], 28);
        check("rep_d3", t_ev[3] - t_ev[0], 36);
        check("rep_d4", t_ev[4] - t_ev[0], 44);
        check("rep_r1", r_ev[1], 1);
        check("rep_r4", r_ev[4], 1);

        // Simultaneous press: lower channel first.
        btn = 4'b0101;
        tick(8);
        check("sim_cnt1", evt_count, 1);
        check("sim_head0", evt_chan, 0);
        tick(1);
        check("sim_cnt2", evt_count, 2);
        tick(1);
        btn = '0;
        evt_ready = 1'b1;
        tick(1);
        check("sim_head2", evt_chan, 2);
        check("sim_cnt_pop", evt_count, 1);
        tick(1);
        evt_ready = 1'b0;
        tick(12);

        // Full FIFO, pending, drop, refill on pop.
        btn = 4'b1111;
        tick(8);
        btn = '0;
        tick(12);
        check("full_count", evt_count, 4);
        check("full_drop0", dropped, 0);
        btn[0] = 1'b1;
        tick(8);
        btn[0] = 1'b0;
        tick(14);
        check("pend_count", evt_count, 4);
        check("pend_drop", dropped, 0);
        btn[0] = 1'b1;
        tick(8);
        btn[0] = 1'b0;
        tick(14);
        check("drop_set", dropped, 1);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("refill_count", evt_count, 4);
        check("refill_head", evt_chan, 1);
        evt_ready = 1'b1;
        tick(4);
        evt_ready = 1'b0;
        check("drain_count", evt_count, 0);
        check("drop_sticky", dropped, 1);

`ifdef PS2_KEYS_EN
        send(8'hE0);
        send(8'h75);
        check("kb_held_on", held[1], 1);
        tick(2);
        check("kb_count", evt_count, 1);
        check("kb_chan", evt_chan, 1);
        check("kb_rep", evt_repeat, 0);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check("kb_held_off", held[1], 0);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        send(8'h1C);
        send(8'hF0);
        send(8'h1C);
        tick(4);
        check("kb_ignore_held", held, 0);
        check("kb_ignore_cnt", evt_count, 0);
`endif

        // Reset mid-operation with queued events and a held button.
        btn = 4'b0111;
        tick(8);
        btn = '0;
        tick(14);
        check("pre_rst_count", evt_count, 3);
        btn[3] = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("mid_rst_count", evt_count, 0);
        check("mid_rst_drop", dropped, 0);
        check("mid_rst_held", held, 0);
        tick(7);
        check("post_rst_c7", evt_valid, 0);
        tick(1);
        check("post_rst_c8", evt_valid, 1);
        check("post_rst_chan", evt_chan, 3);
        check("post_rst_rep", evt_repeat, 0);
        btn = '0;
        tick(12);

        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
